// File: rtl/video_timing_gen_v2_if.sv
// Register-bank / video-output interface of the raster timing generator.
// master: register bank plus video sink; slave: the timing generator.
interface video_timing_gen_v2_if #(
  parameter int unsigned P_CNT_W  = 13,
  parameter int unsigned P_FCNT_W = 16
);
  logic               i_enable;
  logic               i_cfg_load;
  logic               i_interlace;
  logic [P_CNT_W-1:0] i_hs_total;
  logic [P_CNT_W-1:0] i_vs_total;
  logic [P_CNT_W-1:0] i_hsyn_end;
  logic [P_CNT_W-1:0] i_vsyn_lines;
  logic [P_CNT_W-1:0] i_h_act_start;
  logic [P_CNT_W-1:0] i_h_act_end;
  logic [P_CNT_W-1:0] i_v_act_start;
  logic [P_CNT_W-1:0] i_v_act_end;
  logic [P_CNT_W-1:0] i_f2_v_start;
  logic [P_CNT_W-1:0] i_f2_vsyn_hpos;
  logic               i_hs_pol;
  logic               i_vs_pol;

  logic                o_hsyn;
  logic                o_vsyn;
  logic                o_de;
  logic                o_rd;
  logic                o_field;
  logic                o_sof;
  logic [P_FCNT_W-1:0] o_frame_cnt;
  logic                o_cfg_pending;

  modport master (
    output i_enable, i_cfg_load, i_interlace, i_hs_total, i_vs_total,
           i_hsyn_end, i_vsyn_lines, i_h_act_start, i_h_act_end,
           i_v_act_start, i_v_act_end, i_f2_v_start, i_f2_vsyn_hpos,
           i_hs_pol, i_vs_pol,
    input  o_hsyn, o_vsyn, o_de, o_rd, o_field, o_sof, o_frame_cnt,
           o_cfg_pending
  );

  modport slave (
    input  i_enable, i_cfg_load, i_interlace, i_hs_total, i_vs_total,
           i_hsyn_end, i_vsyn_lines, i_h_act_start, i_h_act_end,
           i_v_act_start, i_v_act_end, i_f2_v_start, i_f2_vsyn_hpos,
           i_hs_pol, i_vs_pol,
    output o_hsyn, o_vsyn, o_de, o_rd, o_field, o_sof, o_frame_cnt,
           o_cfg_pending
  );
endinterface

// File: rtl/video_timing_gen_v2.sv
// Raster timing generator: progressive / two-field interlaced timing,
// frame-boundary shadowed configuration, read strobe leading DE.
module video_timing_gen_v2 #(
  parameter int unsigned P_CNT_W   = 13,
  parameter int unsigned P_RD_LEAD = 1,
  parameter int unsigned P_FCNT_W  = 16
) (
  input logic                 i_clk,
  input logic                 i_rst,
  video_timing_gen_v2_if.slave vid
);

  typedef logic [P_CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic interlace;
    logic hs_pol;
    logic vs_pol;
    cnt_t hs_total;
    cnt_t vs_total;
    cnt_t hsyn_end;
    cnt_t vsyn_lines;
    cnt_t h_act_start;
    cnt_t h_act_end;
    cnt_t v_act_start;
    cnt_t v_act_end;
    cnt_t f2_v_start;
    cnt_t f2_vsyn_hpos;
  } shadow_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic field;
    logic sof;
    logic hs_pol;
    logic vs_pol;
  } stage_t;

  localparam int unsigned SW = $bits(stage_t);

  shadow_t           sh;
  shadow_t           sh_in;
  logic              pending;
  logic              upd;
  cnt_t              h;
  cnt_t              v;
  cnt_t              h_inc;
  logic [P_CNT_W:0]  v_inc;
  logic              h_last;
  logic              v_last;
  logic              frame_end;

  logic              f2;
  cnt_t              fl;
  logic              hs_act;
  logic              vs1_act;
  logic              vs2_set;
  logic              vs2_clr;
  logic              vs2_act;
  logic              vs2_q;
  logic              de_act;
  logic              sof_act;

  stage_t            st0_d;
  stage_t            st0;
  stage_t            out_src;

  logic              hsyn_q;
  logic              vsyn_q;
  logic              de_q;
  logic              field_q;
  logic              sof_q;
  logic [P_FCNT_W-1:0] fcnt_q;

  assign sh_in = '{
    interlace:    vid.i_interlace,
    hs_pol:       vid.i_hs_pol,
    vs_pol:       vid.i_vs_pol,
    hs_total:     vid.i_hs_total,
    vs_total:     vid.i_vs_total,
    hsyn_end:     vid.i_hsyn_end,
    vsyn_lines:   vid.i_vsyn_lines,
    h_act_start:  vid.i_h_act_start,
    h_act_end:    vid.i_h_act_end,
    v_act_start:  vid.i_v_act_start,
    v_act_end:    vid.i_v_act_end,
    f2_v_start:   vid.i_f2_v_start,
    f2_vsyn_hpos: vid.i_f2_vsyn_hpos
  };

  assign h_inc     = h + cnt_t'(1);
  assign v_inc     = {1'b0, v} + {{P_CNT_W{1'b0}}, 1'b1};
  assign h_last    = (h >= sh.hs_total);
  assign v_last    = (v_inc >= {1'b0, sh.vs_total});
  assign frame_end = h_last & v_last;
  assign upd       = (pending | vid.i_cfg_load) & (~vid.i_enable | frame_end);

  // Shadow registers adopt the inputs at a frame boundary or while idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh      <= '0;
      pending <= 1'b0;
    end else begin
      if (upd) sh <= sh_in;
      pending <= ~upd & (pending | vid.i_cfg_load);
    end
  end

  // Horizontal / vertical raster counters, parked at (0,0) while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h <= '0;
      v <= '0;
    end else if (!vid.i_enable) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v_inc[P_CNT_W-1:0];
    end else begin
      h <= h_inc;
    end
  end

  assign f2      = sh.interlace & (v >= sh.f2_v_start);
  assign fl      = f2 ? (v - sh.f2_v_start) : v;
  assign hs_act  = (h < sh.hsyn_end);
  assign vs1_act = ~f2 & (v < sh.vsyn_lines);
  assign vs2_set = sh.interlace & (v == sh.f2_v_start) & (h == sh.f2_vsyn_hpos);
  assign vs2_clr = sh.interlace & (h == sh.f2_vsyn_hpos) &
                   ({1'b0, v} == ({1'b0, sh.f2_v_start} + {1'b0, sh.vsyn_lines}));
  // Field-2 vsync is a set/clear latch on exact pixel matches; clear wins so
  // a zero-length vsync never asserts.
  assign vs2_act = ~vs2_clr & (vs2_set | vs2_q);
  assign de_act  = (h >= sh.h_act_start) & (h < sh.h_act_end) &
                   (fl >= sh.v_act_start) & (fl < sh.v_act_end);
  assign sof_act = (h == '0) & (v == '0);

  // Field-2 vsync state, dropped at frame end and while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs2_q <= 1'b0;
    end else if (!vid.i_enable || frame_end) begin
      vs2_q <= 1'b0;
    end else begin
      vs2_q <= vs2_act;
    end
  end

  // Stage-0 decode; polarity travels with the pixel so a shadowed change
  // reaches the pins exactly at the frame boundary.
  always_comb begin
    st0_d        = '0;
    st0_d.hs_pol = sh.hs_pol;
    st0_d.vs_pol = sh.vs_pol;
    if (vid.i_enable) begin
      st0_d.de    = de_act;
      st0_d.hs    = hs_act;
      st0_d.vs    = vs1_act | vs2_act;
      st0_d.field = f2;
      st0_d.sof   = sof_act;
    end
  end

  // Stage-0 register; its DE is the read strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) st0 <= '0;
    else       st0 <= st0_d;
  end

  generate
    if (P_RD_LEAD == 1) begin : g_dly0
      assign out_src = st0;
    end else if (P_RD_LEAD == 2) begin : g_dly1
      stage_t dly;
      // Single delay slot between stage 0 and the output register.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) dly <= '0;
        else       dly <= st0;
      end
      assign out_src = dly;
    end else begin : g_dlyn
      localparam int unsigned DW = SW * (P_RD_LEAD - 1);
      logic [DW-1:0] dly;
      // Shift register of P_RD_LEAD-1 stage slots, newest in the low slot.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) dly <= '0;
        else       dly <= {dly[DW-SW-1:0], st0};
      end
      assign out_src = dly[DW-1 -: SW];
    end
  endgenerate

  // Output register with polarity applied, plus the frame counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hsyn_q  <= 1'b0;
      vsyn_q  <= 1'b0;
      de_q    <= 1'b0;
      field_q <= 1'b0;
      sof_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      hsyn_q  <= out_src.hs_pol ? out_src.hs : ~out_src.hs;
      vsyn_q  <= out_src.vs_pol ? out_src.vs : ~out_src.vs;
      de_q    <= out_src.de;
      field_q <= out_src.field;
      sof_q   <= out_src.sof;
      if (!vid.i_enable)    fcnt_q <= '0;
      else if (out_src.sof) fcnt_q <= fcnt_q + P_FCNT_W'(1);
    end
  end

  assign vid.o_hsyn        = hsyn_q;
  assign vid.o_vsyn        = vsyn_q;
  assign vid.o_de          = de_q;
  assign vid.o_rd          = st0.de;
  assign vid.o_field       = field_q;
  assign vid.o_sof         = sof_q;
  assign vid.o_frame_cnt   = fcnt_q;
  assign vid.o_cfg_pending = pending;

endmodule

// File: tb/tb_video_timing_gen_v2.sv
// Directed bench for video_timing_gen_v2 with P_RD_LEAD=4.
module tb_video_timing_gen_v2;
  localparam int unsigned CW   = 13;
  localparam int unsigned FW   = 16;
  localparam int unsigned LEAD = 4;

  typedef struct {
    int ht, vt, hse, vsl, has, hae, vas, vae, f2s, f2h;
    bit il, hp, vp;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_v2_if #(.P_CNT_W(CW), .P_FCNT_W(FW)) vid ();

  video_timing_gen_v2 #(.P_CNT_W(CW), .P_RD_LEAD(LEAD), .P_FCNT_W(FW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .vid   (vid.slave)
  );

  cfg_t ca, cb;
  int sw, tk, pend_from, pend_to;
  int n_chk = 0;
  int n_fail = 0;

  function automatic cfg_t prog_cfg();
    cfg_t c;
    c = '{ht:9, vt:6, hse:2, vsl:1, has:3, hae:8, vas:2, vae:5,
          f2s:0, f2h:0, il:1'b0, hp:1'b1, vp:1'b1};
    return c;
  endfunction

  // Expected {de, hs_active, vs_active, field} of pixel q of a run using c.
  function automatic logic [3:0] pix(input cfg_t c, input int q);
    int L, F, qq, h, v, fl;
    bit f2, de, hs, vs;
    L  = c.ht + 1;
    F  = L * c.vt;
    qq = q % F;
    h  = qq % L;
    v  = qq / L;
    f2 = c.il && (v >= c.f2s);
    fl = f2 ? v - c.f2s : v;
    de = (h >= c.has) && (h < c.hae) && (fl >= c.vas) && (fl < c.vae);
    hs = h < c.hse;
    if (f2) vs = (qq >= c.f2s * L + c.f2h) && (qq < (c.f2s + c.vsl) * L + c.f2h);
    else    vs = v < c.vsl;
    return {de, hs, vs, f2};
  endfunction

  // Expected {rd,de,hsyn,vsyn,field,sof,pending,frame_cnt} after tick n.
  function automatic logic [22:0] expect_at(input int n);
    int prd, po, q, F, cnt;
    cfg_t c;
    logic [3:0] a;
    bit rd, sof, hsy, vsy, pend;
    prd = n - 1;
    if (prd < sw) a = pix(ca, prd);
    else          a = pix(cb, prd - sw);
    rd = a[3];
    po = n - 1 - int'(LEAD);
    if (po < 0) begin
      c = ca; a = 4'b0000; sof = 1'b0; cnt = 0;
    end else if (po < sw) begin
      c = ca; a = pix(ca, po); F = (ca.ht + 1) * ca.vt;
      sof = (po % F) == 0; cnt = po / F + 1;
    end else begin
      c = cb; q = po - sw; a = pix(cb, q); F = (cb.ht + 1) * cb.vt;
      sof = (q % F) == 0; cnt = sw / ((ca.ht + 1) * ca.vt) + q / F + 1;
    end
    hsy  = c.hp ? a[2] : !a[2];
    vsy  = c.vp ? a[1] : !a[1];
    pend = (n >= pend_from) && (n < pend_to);
    return {rd, a[3], hsy, vsy, a[0], sof, pend, FW'(cnt)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input cfg_t c);
    vid.i_interlace    = c.il;
    vid.i_hs_pol       = c.hp;
    vid.i_vs_pol       = c.vp;
    vid.i_hs_total     = CW'(c.ht);
    vid.i_vs_total     = CW'(c.vt);
    vid.i_hsyn_end     = CW'(c.hse);
    vid.i_vsyn_lines   = CW'(c.vsl);
    vid.i_h_act_start  = CW'(c.has);
    vid.i_h_act_end    = CW'(c.hae);
    vid.i_v_act_start  = CW'(c.vas);
    vid.i_v_act_end    = CW'(c.vae);
    vid.i_f2_v_start   = CW'(c.f2s);
    vid.i_f2_vsyn_hpos = CW'(c.f2h);
  endtask

  task automatic load_idle(input cfg_t c);
    vid.i_enable   = 1'b0;
    apply_cfg(c);
    vid.i_cfg_load = 1'b1;
    tick();
    vid.i_cfg_load = 1'b0;
    repeat (LEAD + 2) tick();
    ca = c; cb = c; sw = 1 << 30; tk = 0; pend_from = 0; pend_to = 0;
  endtask

  task automatic start();
    vid.i_enable = 1'b1;
    tk = 0;
  endtask

  task automatic step(output logic [22:0] obs, output logic [22:0] exp);
    tick();
    tk++;
    obs = {vid.o_rd, vid.o_de, vid.o_hsyn, vid.o_vsyn, vid.o_field, vid.o_sof,
           vid.o_cfg_pending, vid.o_frame_cnt};
    exp = expect_at(tk);
  endtask

  task automatic test_reset();
    logic [22:0] got;
    cfg_t z;
    z = '{ht:0, vt:0, hse:0, vsl:0, has:0, hae:0, vas:0, vae:0,
          f2s:0, f2h:0, il:1'b0, hp:1'b0, vp:1'b0};
    apply_cfg(z);
    vid.i_enable   = 1'b0;
    vid.i_cfg_load = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    got = {vid.o_rd, vid.o_de, vid.o_hsyn, vid.o_vsyn, vid.o_field, vid.o_sof,
           vid.o_cfg_pending, vid.o_frame_cnt};
    n_chk++;
    if (got !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", got);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_progressive();
    logic [22:0] o, e;
    load_idle(prog_cfg());
    start();
    for (int i = 0; i < 130; i++) begin
      step(o, e);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL progressive tick %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tk, o[22:16], o[15:0], e[22:16], e[15:0]);
      end
    end
  endtask

  task automatic test_interlace();
    logic [22:0] o, e;
    cfg_t c;
    c = '{ht:9, vt:12, hse:2, vsl:1, has:3, hae:8, vas:2, vae:5,
          f2s:6, f2h:5, il:1'b1, hp:1'b1, vp:1'b1};
    load_idle(c);
    start();
    for (int i = 0; i < 250; i++) begin
      step(o, e);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL interlace tick %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tk, o[22:16], o[15:0], e[22:16], e[15:0]);
      end
    end
  endtask

  task automatic test_cfg_load_midframe();
    logic [22:0] o, e;
    cfg_t c;
    load_idle(prog_cfg());
    start();
    for (int i = 0; i < 200; i++) begin
      if (i == 25) begin
        c = prog_cfg();
        c.ht = 19;
        apply_cfg(c);
        vid.i_cfg_load = 1'b1;
        cb = c; sw = 60; pend_from = 26; pend_to = 60;
      end
      if (i == 26) vid.i_cfg_load = 1'b0;
      step(o, e);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cfg_load tick %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tk, o[22:16], o[15:0], e[22:16], e[15:0]);
      end
    end
  endtask

  task automatic test_polarity();
    logic [22:0] o, e;
    logic [3:0] idle;
    cfg_t c;
    c = prog_cfg();
    c.hp = 1'b0;
    c.vp = 1'b0;
    load_idle(c);
    start();
    for (int i = 0; i < 75; i++) begin
      step(o, e);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL polarity tick %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tk, o[22:16], o[15:0], e[22:16], e[15:0]);
      end
    end
    vid.i_enable = 1'b0;
    repeat (LEAD + 1) tick();
    idle = {vid.o_rd, vid.o_de, vid.o_hsyn, vid.o_vsyn};
    n_chk++;
    if (idle !== 4'b0011) begin
      n_fail++;
      $display("FAIL polarity_idle got rd/de/hs/vs=%b want 0011", idle);
    end
  endtask

  task automatic test_rd_lead_sof();
    logic [22:0] o, e;
    int first_rd, first_de;
    cfg_t c;
    c = '{ht:9, vt:4, hse:3, vsl:2, has:0, hae:4, vas:0, vae:2,
          f2s:0, f2h:0, il:1'b0, hp:1'b1, vp:1'b1};
    load_idle(c);
    start();
    first_rd = -1;
    first_de = -1;
    for (int i = 0; i < 50; i++) begin
      step(o, e);
      if (first_rd < 0 && vid.o_rd === 1'b1) first_rd = tk;
      if (first_de < 0 && vid.o_de === 1'b1) first_de = tk;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rd_lead tick %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tk, o[22:16], o[15:0], e[22:16], e[15:0]);
      end
    end
    n_chk++;
    if (first_de - first_rd !== int'(LEAD)) begin
      n_fail++;
      $display("FAIL rd_lead_gap got %0d want %0d", first_de - first_rd, LEAD);
    end
  endtask

  task automatic test_disable_and_reset();
    logic [22:0] o, e, got;
    load_idle(prog_cfg());
    start();
    for (int i = 0; i < 33; i++) begin
      step(o, e);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL pre_disable tick %0d got flags=%b want flags=%b", tk, o[22:16], e[22:16]);
      end
    end
    // Counter is at (h=3, v=3) here; drop enable mid-line.
    vid.i_enable = 1'b0;
    tick();
    n_chk++;
    if (vid.o_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_rd got %b want 0", vid.o_rd);
    end
    repeat (LEAD) tick();
    got = {vid.o_rd, vid.o_de, vid.o_hsyn, vid.o_vsyn, vid.o_field, vid.o_sof,
           vid.o_cfg_pending, vid.o_frame_cnt};
    n_chk++;
    if (got !== 23'd0) begin
      n_fail++;
      $display("FAIL disable_flush got=%h want=0", got);
    end
    start();
    for (int i = 0; i < 40; i++) begin
      step(o, e);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reenable tick %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tk, o[22:16], o[15:0], e[22:16], e[15:0]);
      end
    end
    #3;
    rst = 1'b1;
    #1;
    got = {vid.o_rd, vid.o_de, vid.o_hsyn, vid.o_vsyn, vid.o_field, vid.o_sof,
           vid.o_cfg_pending, vid.o_frame_cnt};
    n_chk++;
    if (got !== 23'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=0", got);
    end
    vid.i_enable = 1'b0;
    tick();
    rst = 1'b0;
    load_idle(prog_cfg());
    start();
    for (int i = 0; i < int'(LEAD) + 3; i++) begin
      step(o, e);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL post_reset tick %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 tk, o[22:16], o[15:0], e[22:16], e[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_progressive();
    test_interlace();
    test_cfg_load_midframe();
    test_polarity();
    test_rd_lead_sof();
    test_disable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen_v2.md
# video_timing_gen_v2

Parametrised raster timing generator, successor to the fixed 13-bit frame timing block. Produces hsync/vsync/DE plus a read-ahead strobe for the upstream frame-buffer reader. Native progressive and interlaced (two-field, half-line vsync offset) modes, programmable sync polarity, frame-boundary shadowing of all timing registers, and a parametrised read-ahead lead. Sits between the register bank and the video output / DMA read path.

## Interface
- P_CNT_W, 13, width of horizontal/vertical counters and all timing inputs
- P_RD_LEAD, 1, cycles by which o_rd leads o_de; legal 1..4
- P_FCNT_W, 16, width of o_frame_cnt
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, reset is asynchronous and active-high
- i_enable  in  1  generator run enable
- i_cfg_load  in  1  one-cycle request to adopt new timing inputs
- i_interlace  in  1  1 = two-field mode
- i_hs_total  in  P_CNT_W  last pixel index of a line (line length = value+1)
- i_vs_total  in  P_CNT_W  lines per frame (lines 0..value-1)
- i_hsyn_end  in  P_CNT_W  hsync active for h < value
- i_vsyn_lines  in  P_CNT_W  vsync length in lines
- i_h_act_start / i_h_act_end  in  P_CNT_W  DE columns: start <= h < end
- i_v_act_start / i_v_act_end  in  P_CNT_W  DE lines in field coordinates: start <= fl < end
- i_f2_v_start  in  P_CNT_W  first frame line of field 2
- i_f2_vsyn_hpos  in  P_CNT_W  pixel at which field-2 vsync asserts/deasserts
- i_hs_pol / i_vs_pol  in  1  1 = active-high sync output
- o_hsyn / o_vsyn  out  1  syncs, polarity applied
- o_de  out  1  data enable
- o_rd  out  1  read strobe, o_de shifted earlier by P_RD_LEAD
- o_field  out  1  0 = field 1 / progressive, 1 = field 2
- o_sof  out  1  one-cycle pulse on the first pixel (h=0,v=0), aligned with o_de
- o_frame_cnt  out  P_FCNT_W  frames started since enable, wraps
- o_cfg_pending  out  1  load requested, not yet applied

## Operation
- Shadow set: all timing inputs plus i_interlace and polarities. i_cfg_load sets pending. Shadow copies inputs when pending and (enable low, or h=hs_total and v=vs_total-1). Load coinciding with the boundary applies at that boundary; pending clears as shadow updates. A load while enable is low applies next cycle.
- Counters: h 0..hs_total, wraps to 0; v increments on h wrap, 0 after vs_total-1. Enable low: h=v=0 next cycle. First enabled cycle counts from (0,0).
- Field: interlace=1 and v >= f2_v_start -> field 2, fl = v-f2_v_start; otherwise field 1, fl = v.
- hsync active: h < hsyn_end. Field-1 vsync: v < vsyn_lines. Field-2 vsync: from (v=f2_v_start, h=f2_vsyn_hpos) inclusive to (v=f2_v_start+vsyn_lines, h=f2_vsyn_hpos) exclusive; set/clear on exact pixel match, so it spans lines.
- DE: h_act_start <= h < h_act_end and v_act_start <= fl < v_act_end; in interlace, field-1 DE also requires v < f2_v_start. Windows beyond totals clip naturally; start >= end gives no DE.
- Comparisons unsigned, full P_CNT_W; v+vsyn_lines computed in P_CNT_W+1 bits, no wrap.
- o_frame_cnt: 0 while enable low; increments on each o_sof.

## Timing
- Reset: counters 0, shadow 0, pending 0; o_de/o_rd/o_sof/o_field 0, o_frame_cnt 0, o_hsyn/o_vsyn 0.
- Stage 0: decode of (h,v) registered; o_rd = stage-0 DE (1 cycle after counter).
- o_de, o_hsyn, o_vsyn, o_field, o_sof = stage 0 delayed P_RD_LEAD cycles (counter->o_de = 1+P_RD_LEAD).
- Polarity inversion applied at output register; shadowed polarity change takes effect at the frame boundary, no glitch mid-frame.
- Enable low mid-frame: stage 0 forced inactive next cycle; delay line flushes, all outputs inactive (syncs at inactive level) within P_RD_LEAD+1 cycles; no partial-frame sof.
- i_rst mid-frame: all state cleared immediately; restart from (0,0) after release with enable high.

## Test plan
- Progressive hs_total=9, vs_total=6, hsyn_end=2, vsyn_lines=1, h_act 3..8, v_act 2..5, pols=1 -> 60-cycle frame, o_hsyn high 2 clk/line, o_de 5 clk on lines 2-4, o_rd same pattern P_RD_LEAD earlier.
- Interlace vs_total=12, f2_v_start=6, f2_vsyn_hpos=5, vsyn_lines=1 -> field-2 vsync high from (6,5) to (7,4), o_field=1 for v 6-11, DE on fl 2-4 each field.
- Load mid-frame with hs_total=19 -> o_cfg_pending=1 until boundary, current frame stays 10-pixel lines, next frame 20-pixel lines.
- i_hs_pol=0, i_vs_pol=0 -> syncs low-active; idle level 1 while enabled-but-inactive.
- P_RD_LEAD=4 -> o_rd rises exactly 4 cycles before o_de; o_sof coincident with first o_de frame cycle (if h_act_start=0).
- Enable dropped at v=3 then i_rst mid-frame -> outputs inactive within P_RD_LEAD+1, o_frame_cnt 0; re-enable -> o_sof after 1+P_RD_LEAD cycles, o_frame_cnt=1.
